mem_access_stage: RTL

Pipeline memory stage for the MIPS datapath: takes the EX/MEM operands, performs word/half/byte loads and stores against a handshaked data memory, and registers the results into the MEM/WB register that drives the write-back stage. It stalls the upstream pipeline while a memory access is outstanding and inserts bubbles into write-back during the stall.

---
 rtl/mem_access_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MIPS memory stage. Takes the EX/MEM operands, runs word/half/byte loads
//   and stores against a handshaked data memory, and registers the result
//   into the MEM/WB register. While an access is outstanding it holds the
//   upstream pipeline and feeds bubbles to write-back.
//
//   Ports
//     Clock, Reset           pipeline clock; asynchronous active-high reset
//     in_valid .. rDest      EX/MEM operands (control, address, store data)
//     Stall                  upstream must hold EX/MEM contents this cycle
//     mem_req .. mem_rdata   data-memory handshake; request held until mem_ready
//     wb_*                   MEM/WB register fields
//     AlignErr               sticky misalignment flag
//
//   Build option
//     MEM_ALIGN_CHECK_EN  misaligned half/word accesses skip memory, reach
//                         write-back with RegWrite cleared and set AlignErr.
//                         When undefined, low address bits are ignored for
//                         alignment and AlignErr is tied 0.
module mem_access_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              in_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        MemSize,
    input  logic              MemSigned,
    input  logic              RegWrite,
    input  logic              MemToReg,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    input  logic [4:0]        rDest,
    output logic              Stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic              wb_MemToReg,
    output logic [31:0]       wb_R_Data,
    output logic [31:0]       wb_ALUResult,
    output logic [4:0]        wb_rDestSelected,
    output logic              AlignErr
);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state;

    logic       isMem, isWord, isHalf, isByte, misalign;
    logic [1:0] off;
    logic [3:0] beNext;
    logic [31:0] wdataNext;

    assign isMem  = MemRead | MemWrite;
    assign off    = ALUResult[1:0];
    assign isHalf = (MemSize == 2'b01);
    assign isByte = (MemSize == 2'b10);
    assign isWord = !isHalf && !isByte;   // 11 behaves as word

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (isHalf && off[0]) || (isWord && (off != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Lane enables and lane-replicated store data for the incoming op.
    always_comb begin
        beNext    = 4'b1111;
        wdataNext = WriteData;
        if (isHalf) begin
            beNext    = off[1] ? 4'b1100 : 4'b0011;
            wdataNext = {2{WriteData[15:0]}};
        end else if (isByte) begin
            beNext    = 4'b0001 << off;
            wdataNext = {4{WriteData[7:0]}};
        end
    end

    // Fields of the instruction held across the access.
    logic        lStore, lRegWrite, lMemToReg, lHalf, lByte, lSigned;
    logic [1:0]  lOff;
    logic [31:0] lALU;
    logic [4:0]  lRDest;

    // Load extraction: right-justify the addressed lane, then extend.
    logic [31:0] shifted, loadData;
    assign shifted = mem_rdata >> {lOff, 3'b000};
    always_comb begin
        loadData = mem_rdata;
        if (lByte)
            loadData = {{24{lSigned & shifted[7]}}, shifted[7:0]};
        else if (lHalf)
            loadData = {{16{lSigned & shifted[15]}}, shifted[15:0]};
    end

    assign Stall = !Reset &&
                   (((state == IDLE) && in_valid && isMem && !misalign) ||
                    ((state == ACCESS) && !mem_ready));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            mem_req <= 1'b0; mem_we <= 1'b0; mem_addr <= '0;
            mem_be <= 4'b0; mem_wdata <= 32'b0;
            wb_valid <= 1'b0; wb_RegWrite <= 1'b0; wb_MemToReg <= 1'b0;
            wb_R_Data <= 32'b0; wb_ALUResult <= 32'b0; wb_rDestSelected <= 5'b0;
            lStore <= 1'b0; lRegWrite <= 1'b0; lMemToReg <= 1'b0;
            lHalf <= 1'b0; lByte <= 1'b0; lSigned <= 1'b0; lOff <= 2'b0;
            lALU <= 32'b0; lRDest <= 5'b0;
        end else begin
            // Bubble unless a branch below loads a real instruction.
            wb_valid <= 1'b0; wb_RegWrite <= 1'b0; wb_MemToReg <= 1'b0;
            wb_R_Data <= 32'b0; wb_ALUResult <= 32'b0; wb_rDestSelected <= 5'b0;
            case (state)
                IDLE: begin
                    if (in_valid && isMem && !misalign) begin
                        lStore <= MemWrite;   // read+write counts as store
                        lRegWrite <= RegWrite; lMemToReg <= MemToReg;
                        lHalf <= isHalf; lByte <= isByte; lSigned <= MemSigned;
                        lOff <= off; lALU <= ALUResult; lRDest <= rDest;
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= {ALUResult[ADDR_W-1:2], 2'b00};
                        mem_be    <= beNext;
                        mem_wdata <= wdataNext;
                        state     <= ACCESS;
                    end else if (in_valid) begin
                        // Non-memory op, or a rejected misaligned access.
                        wb_valid <= 1'b1;
                        wb_RegWrite <= RegWrite && !isMem;
                        wb_MemToReg <= MemToReg;
                        wb_ALUResult <= ALUResult;
                        wb_rDestSelected <= rDest;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_RegWrite <= lRegWrite;
                        wb_MemToReg <= lMemToReg;
                        wb_R_Data <= lStore ? 32'b0 : loadData;
                        wb_ALUResult <= lALU;
                        wb_rDestSelected <= lRDest;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            AlignErr <= 1'b0;
        else if ((state == IDLE) && in_valid && isMem && misalign)
            AlignErr <= 1'b1;
    end
`else
    assign AlignErr = 1'b0;
`endif

endmodule
